// File: rtl/ram_loader.sv
// ram_loader: fills a DEPTH x DATA_W program memory from a valid/ready byte
// stream, one write strobe per byte, then optionally reads every location
// back and compares it against a shadow copy. The CPU is held off the bus
// while a load or verify is in progress; the result is a sticky done/error.
module ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_ce,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_VRD   = 3'd3,
        S_VCMP  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic              VERIFY_EN = (VERIFY != 0);

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] wdata_s;
    logic [ADDR_W-1:0] err_addr_r;
    logic [ADDR_W-1:0] err_addr_s;
    logic              shadow_we_s;
    logic [DATA_W-1:0] shadow_r [DEPTH];

    logic              in_ready_r;
    logic              in_ready_s;
    logic              we_r;
    logic              we_s;
    logic              ce_r;
    logic              ce_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              error_r;
    logic              error_s;

    logic              last_s;
    logic              match_s;

    // The last-address test is what stops the counter from wrapping.
    function automatic logic is_last(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR);
    endfunction

    assign last_s  = is_last(addr_r);
    assign match_s = (mem_rdata == shadow_r[addr_r]);

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only looked at in the idle/terminal states.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_WRITE: begin
                if (!last_s) begin
                    state_s = S_LOAD;
                end else if (VERIFY_EN) begin
                    state_s = S_VRD;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_VRD: begin
                state_s = S_VCMP;
            end
            S_VCMP: begin
                if (!match_s) begin
                    state_s = S_ERR;
                end else if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_VRD;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Datapath next values: address counter, write data, shadow capture, error address.
    always_comb begin
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        err_addr_s  = err_addr_r;
        shadow_we_s = 1'b0;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    addr_s = ADDR_ZERO;
                end else begin
                    addr_s = addr_r;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    wdata_s     = in_data;
                    shadow_we_s = 1'b1;
                end else begin
                    wdata_s     = wdata_r;
                    shadow_we_s = 1'b0;
                end
            end
            S_WRITE: begin
                if (!last_s) begin
                    addr_s = addr_r + ADDR_ONE;
                end else if (VERIFY_EN) begin
                    addr_s = ADDR_ZERO;
                end else begin
                    addr_s = addr_r;
                end
            end
            S_VCMP: begin
                if (!match_s) begin
                    err_addr_s = addr_r;
                end else if (!last_s) begin
                    addr_s = addr_r + ADDR_ONE;
                end else begin
                    addr_s = addr_r;
                end
            end
            default: begin
                addr_s = addr_r;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register in step with it.
    always_comb begin
        in_ready_s = 1'b0;
        we_s       = 1'b0;
        ce_s       = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        error_s    = 1'b0;
        case (state_s)
            S_LOAD: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            S_WRITE: begin
                we_s   = 1'b1;
                busy_s = 1'b1;
            end
            S_VRD, S_VCMP: begin
                ce_s   = 1'b1;
                busy_s = 1'b1;
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            S_ERR: begin
                error_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            addr_r     <= ADDR_ZERO;
            wdata_r    <= {DATA_W{1'b0}};
            err_addr_r <= ADDR_ZERO;
            in_ready_r <= 1'b0;
            we_r       <= 1'b0;
            ce_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            err_addr_r <= err_addr_s;
            in_ready_r <= in_ready_s;
            we_r       <= we_s;
            ce_r       <= ce_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    // Shadow copy of every accepted byte; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (shadow_we_s) begin
            shadow_r[addr_r] <= wdata_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_we    = we_r;
    assign mem_ce    = ce_r;
    assign busy      = busy_r;
    assign cpu_hold  = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign err_addr  = err_addr_r;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a VERIFY=1 instance with a synchronous RAM model
// (optionally corrupting one read) and a VERIFY=0 instance. Expected writes,
// reads and completion times go into queues; monitors pop and compare.
module tb_ram_loader;

    localparam int N = 16;

    logic       clk    = 1'b0;
    logic       clr_n  = 1'b1;
    logic       start  = 1'b0;
    logic       start0 = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       in_ready, mem_we, mem_ce, busy, cpu_hold, done, error;
    logic [3:0] mem_addr, err_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic       in_ready0, mem_we0, mem_ce0, busy0, cpu_hold0, done0, error0;
    logic [3:0] mem_addr0, err_addr0;
    logic [7:0] mem_wdata0;
    logic [7:0] mem_rdata0 = 8'h00;

    ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .VERIFY(1)) u1 (
        .clk(clk), .clr_n(clr_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ce(mem_ce), .mem_rdata(mem_rdata), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .error(error), .err_addr(err_addr)
    );

    ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .VERIFY(0)) u0 (
        .clk(clk), .clr_n(clr_n), .start(start0), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .mem_ce(mem_ce0), .mem_rdata(mem_rdata0), .busy(busy0), .cpu_hold(cpu_hold0),
        .done(done0), .error(error0), .err_addr(err_addr0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: read data appears one cycle after ce/addr.
    logic [7:0] ram [N];
    bit         force_en = 1'b0;
    logic [3:0] force_addr = 4'h0;
    logic [7:0] force_val  = 8'h00;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_ce) mem_rdata <= (force_en && mem_addr == force_addr) ? force_val : ram[mem_addr];
    end

    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { bit is_err; int at; logic [3:0] ea; } ev_t;

    wr_t        wq[$];
    wr_t        wq0[$];
    logic [3:0] rq[$];
    ev_t        evq[$];
    int         ev0q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the verifying instance.
    logic       prev_ce = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic [3:0] prev_addr = 4'h0;
    always @(negedge clk) begin
        wr_t        w;
        ev_t        e;
        logic [3:0] ra;
        if (clr_n) begin
            if (mem_we) begin
                if (wq.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hffff);
                else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.a));
                    check("wr_data", 32'(mem_wdata), 32'(w.d));
                end
            end
            if (mem_ce && (!prev_ce || mem_addr != prev_addr)) begin
                if (rq.size() == 0) check("unexpected_read", 32'(mem_addr), 32'hffff);
                else begin
                    ra = rq.pop_front();
                    check("rd_addr", 32'(mem_addr), 32'(ra));
                end
            end
            if (mem_we && mem_ce) check("we_ce_exclusive", 32'd1, 32'd0);
            check("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if ((done && !prev_done) || (error && !prev_err)) begin
                if (evq.size() == 0) check("unexpected_end", 32'(cyc), 32'hffff);
                else begin
                    e = evq.pop_front();
                    check("end_error", 32'(error), 32'(e.is_err));
                    check("end_done", 32'(done), 32'(!e.is_err));
                    check("end_cycle", 32'(cyc), 32'(e.at));
                    check("end_busy", 32'({busy, cpu_hold}), 32'd0);
                    if (e.is_err) check("err_addr", 32'(err_addr), 32'(e.ea));
                end
            end
        end
        prev_ce   <= mem_ce;
        prev_addr <= mem_addr;
        prev_done <= done;
        prev_err  <= error;
    end

    // Monitor for the non-verifying instance.
    logic prev_done0 = 1'b0;
    always @(negedge clk) begin
        wr_t w;
        int  at;
        if (clr_n) begin
            if (mem_we0) begin
                if (wq0.size() == 0) check("v0_unexpected_write", 32'(mem_addr0), 32'hffff);
                else begin
                    w = wq0.pop_front();
                    check("v0_wr_addr", 32'(mem_addr0), 32'(w.a));
                    check("v0_wr_data", 32'(mem_wdata0), 32'(w.d));
                end
            end
            if (mem_ce0) check("v0_ce_never", 32'(mem_ce0), 32'd0);
            check("v0_hold_eq_busy", 32'(cpu_hold0), 32'(busy0));
            if (done0 && !prev_done0) begin
                if (ev0q.size() == 0) check("v0_unexpected_done", 32'(cyc), 32'hffff);
                else begin
                    at = ev0q.pop_front();
                    check("v0_done_cycle", 32'(cyc), 32'(at));
                end
            end
        end
        prev_done0 <= done0;
    end

    logic [7:0] stream [N];
    logic [7:0] happy  [N] = '{8'h08, 8'h1a, 8'he0, 8'h0d, 8'h2e, 8'he0, 8'h00, 8'h00,
                               8'h10, 8'h00, 8'h02, 8'h05, 8'h12, 8'h13, 8'h03, 8'h00};

    task automatic randomize_stream();
        for (int i = 0; i < N; i++) stream[i] = 8'($urandom);
    endtask

    // One load: the model predicts every write, every read and the end event.
    task automatic run_load(input int gap_at, input int gap_len, input int start_at,
                            input int vrd_at, input int stop_at, input bit both);
        int         err_idx = -1;
        int         t0, idx, gaps, guard;
        bit         pulsed;
        ev_t        ev;
        wr_t        w;
        logic [7:0] rb;
        idx = 0; gaps = 0; guard = 0; pulsed = 1'b0;
        for (int i = 0; i < N; i++) begin
            rb = (force_en && i == int'(force_addr)) ? force_val : stream[i];
            if (err_idx < 0 && rb != stream[i]) err_idx = i;
        end
        @(negedge clk);
        start = 1'b1;
        if (both) start0 = 1'b1;
        @(negedge clk);
        start = 1'b0; start0 = 1'b0;
        t0 = cyc;
        check("start_clears", 32'({done, error, mem_we, mem_ce}), 32'd0);
        check("start_busy", 32'({busy, cpu_hold, in_ready}), 32'd7);
        check("start_addr", 32'(mem_addr), 32'd0);
        ev.is_err = (err_idx >= 0);
        ev.at     = t0 + 2 * N + gap_len + ((err_idx < 0) ? 2 * N : 2 * (err_idx + 1));
        ev.ea     = (err_idx < 0) ? 4'h0 : 4'(err_idx);
        evq.push_back(ev);
        for (int i = 0; i < N && (err_idx < 0 || i <= err_idx); i++) rq.push_back(4'(i));
        if (both) begin
            ev0q.push_back(t0 + 2 * N);
            for (int i = 0; i < N; i++) begin
                w.a = 4'(i); w.d = stream[i];
                wq0.push_back(w);
            end
        end
        while (idx < N && guard < 400) begin
            if (idx == gap_at && gaps < gap_len && in_ready) begin
                in_valid = 1'b0;
                gaps++;
                check("gap_addr", 32'(mem_addr), 32'(idx));
            end else begin
                in_valid = 1'b1;
                in_data  = stream[idx];
                if (in_ready) begin
                    w.a = 4'(idx); w.d = stream[idx];
                    wq.push_back(w);
                    if (idx == start_at) start = 1'b1;
                    idx++;
                    if (idx > stop_at) return;
                end
            end
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        if (idx < N) check("byte_stall", 32'(idx), 32'(N));
        in_data = 8'($urandom);
        guard = 0;
        while ((evq.size() != 0 || ev0q.size() != 0) && guard < 300) begin
            @(negedge clk);
            #1;
            if (vrd_at >= 0 && !pulsed && mem_ce && int'(mem_addr) == vrd_at) begin
                start = 1'b1;
                pulsed = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            guard++;
        end
        if (guard >= 300) begin
            check("completion_timeout", 32'(evq.size() + ev0q.size()), 32'd0);
            evq.delete(); ev0q.delete();
        end
        in_valid = 1'b0;
        check("reads_left", 32'(rq.size()), 32'd0);
        check("writes_left", 32'(wq.size() + wq0.size()), 32'd0);
        rq.delete(); wq.delete(); wq0.delete();
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({in_ready, mem_addr, mem_wdata, mem_we, mem_ce, busy, cpu_hold, done, error, err_addr}), 32'd0);
        check({name, "_v0"}, 32'({in_ready0, mem_addr0, mem_wdata0, mem_we0, mem_ce0, busy0, cpu_hold0, done0, error0, err_addr0}), 32'd0);
    endtask

    initial begin
        #1 clr_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Happy path with the fixed program.
        stream = happy;
        run_load(-1, 0, -1, -1, N, 1'b0);
        for (int i = 0; i < N; i++) check("t1_ram", 32'(ram[i]), 32'(happy[i]));
        check("t1_flags", 32'({done, error, busy}), 32'd4);

        // Backpressure: 3 idle LOAD cycles before byte 5, restarted from DONE.
        randomize_stream();
        run_load(5, 3, -1, -1, N, 1'b0);
        for (int i = 0; i < N; i++) check("t2_ram", 32'(ram[i]), 32'(stream[i]));

        // Verify mismatch at address 5.
        stream = happy;
        force_en = 1'b1; force_addr = 4'd5; force_val = 8'h00;
        run_load(-1, 0, -1, -1, N, 1'b0);
        check("t3_flags", 32'({error, done, busy}), 32'd4);
        check("t3_err_addr", 32'(err_addr), 32'd5);
        repeat (3) @(negedge clk);
        check("t3_sticky", 32'({error, err_addr}), 32'h15);
        force_en = 1'b0;

        // Start pulses in LOAD and VRD are ignored; load begins from ERR.
        randomize_stream();
        run_load(-1, 0, 3, 3, N, 1'b0);
        check("t5_done", 32'({done, error}), 32'd2);

        // Reset during the WRITE of address 7.
        randomize_stream();
        run_load(-1, 0, -1, -1, 7, 1'b0);
        @(negedge clk);
        check("t4_in_write", 32'({mem_we, mem_addr}), 32'h17);
        #2 clr_n = 1'b0;
        #1 check("t4_we_async_drop", 32'(mem_we), 32'd0);
        check_all_zero("t4_reset_outputs");
        evq.delete(); rq.delete(); wq.delete();
        @(negedge clk);
        clr_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_idle_ignores", 32'({in_ready, busy, mem_we}), 32'd0);
        end
        in_valid = 1'b0;

        // VERIFY=0 instance alongside the verifying one.
        stream = happy;
        run_load(-1, 0, -1, -1, N, 1'b1);
        check("t6_v0_flags", 32'({done0, error0, busy0, err_addr0}), 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
